// File: rtl/instr_trace_buffer.sv
// Retire-trace capture: decodes each retired instruction into a class, counts per class,
// and stores {pc, class, write-data} in a circular buffer drained via valid/ready.
module instr_trace_buffer #(
   parameter int DEPTH  = 16,
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ret_valid,
   input  logic [PC_W-1:0]            ret_pc,
   input  logic [31:0]                ret_instr,
   input  logic [DATA_W-1:0]          ret_wd,
   input  logic                       mode,
   input  logic                       freeze,
   input  logic                       clear,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [PC_W-1:0]            rd_pc,
   output logic [4:0]                 rd_class,
   output logic [DATA_W-1:0]          rd_wd,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic [CNT_W-1:0]           drop_cnt,
   input  logic [4:0]                 cnt_sel,
   output logic [CNT_W-1:0]           cnt_out
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int NCLS = 17;

   function automatic logic [4:0] decode_class(input logic [31:0] instr);
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] cls;
      op = instr[31:26];
      fn = instr[5:0];
      if (instr == 32'd0) begin
         cls = 5'd0;
      end else if (op == 6'd0) begin
         case (fn)
            6'd32:   cls = 5'd1;
            6'd34:   cls = 5'd2;
            6'd36:   cls = 5'd3;
            6'd37:   cls = 5'd4;
            6'd8:    cls = 5'd5;
            6'd0:    cls = 5'd6;
            6'd42:   cls = 5'd7;
            6'd25:   cls = 5'd8;
            6'd10:   cls = 5'd9;
            6'd12:   cls = 5'd10;
            default: cls = 5'd16;
         endcase
      end else begin
         case (op)
            6'd12:   cls = 5'd11;
            6'd35:   cls = 5'd12;
            6'd43:   cls = 5'd13;
            6'd4:    cls = 5'd14;
            6'd2:    cls = 5'd15;
            default: cls = 5'd16;
         endcase
      end
      return cls;
   endfunction

   logic [PC_W-1:0]   mem_pc_r    [DEPTH];
   logic [4:0]        mem_class_r [DEPTH];
   logic [DATA_W-1:0] mem_wd_r    [DEPTH];

   logic [AW-1:0]     head_r, tail_r;
   logic [CW-1:0]     count_r, count_nxt_s;
   logic              full_r, rd_valid_r;
   logic [CNT_W-1:0]  drop_r, cnt_out_r, cnt_out_nxt_s;
   logic [CNT_W-1:0]  cls_cnt_r     [NCLS];
   logic [CNT_W-1:0]  cls_cnt_nxt_s [NCLS];

   logic [4:0]        class_s;
   logic              event_s, pop_s, push_s, adv_s, drop_s;

   // Push/pop decisions; a wrap-mode overwrite and a pop share one head advance.
   always_comb begin
      class_s = decode_class(ret_instr);
      event_s = ret_valid & ~freeze & ~clear;
      pop_s   = rd_valid_r & rd_ready & ~clear;
      push_s  = event_s & (~full_r | pop_s | mode);
      adv_s   = pop_s | (event_s & full_r & mode);
      drop_s  = event_s & full_r & ~pop_s;
      if (clear) begin
         count_nxt_s = {CW{1'b0}};
      end else if (push_s && !adv_s) begin
         count_nxt_s = count_r + CW'(1);
      end else if (adv_s && !push_s) begin
         count_nxt_s = count_r - CW'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Saturating per-class counter increments and the selected-counter lookahead.
   always_comb begin
      for (int i = 0; i < NCLS; i++) begin
         if (event_s && (class_s == 5'(i)) && (cls_cnt_r[i] != {CNT_W{1'b1}})) begin
            cls_cnt_nxt_s[i] = cls_cnt_r[i] + CNT_W'(1);
         end else begin
            cls_cnt_nxt_s[i] = cls_cnt_r[i];
         end
      end
      if (cnt_sel < 5'(NCLS)) begin
         cnt_out_nxt_s = cls_cnt_nxt_s[cnt_sel];
      end else begin
         cnt_out_nxt_s = {CNT_W{1'b0}};
      end
   end

   // Entry storage; contents are masked at the output while empty, so no reset needed.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_pc_r[tail_r]    <= ret_pc;
         mem_class_r[tail_r] <= class_s;
         mem_wd_r[tail_r]    <= ret_wd;
      end
   end

   // Pointers, occupancy, drop and class counters; clear dominates everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_r     <= {AW{1'b0}};
         tail_r     <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         full_r     <= 1'b0;
         rd_valid_r <= 1'b0;
         drop_r     <= {CNT_W{1'b0}};
         cnt_out_r  <= {CNT_W{1'b0}};
         for (int i = 0; i < NCLS; i++) cls_cnt_r[i] <= {CNT_W{1'b0}};
      end else if (clear) begin
         head_r     <= {AW{1'b0}};
         tail_r     <= {AW{1'b0}};
         count_r    <= {CW{1'b0}};
         full_r     <= 1'b0;
         rd_valid_r <= 1'b0;
         drop_r     <= {CNT_W{1'b0}};
         cnt_out_r  <= {CNT_W{1'b0}};
         for (int i = 0; i < NCLS; i++) cls_cnt_r[i] <= {CNT_W{1'b0}};
      end else begin
         head_r     <= adv_s ? head_r + AW'(1) : head_r;
         tail_r     <= push_s ? tail_r + AW'(1) : tail_r;
         count_r    <= count_nxt_s;
         full_r     <= (count_nxt_s == CW'(DEPTH));
         rd_valid_r <= (count_nxt_s != {CW{1'b0}});
         drop_r     <= (drop_s && drop_r != {CNT_W{1'b1}}) ? drop_r + CNT_W'(1) : drop_r;
         cnt_out_r  <= cnt_out_nxt_s;
         for (int i = 0; i < NCLS; i++) cls_cnt_r[i] <= cls_cnt_nxt_s[i];
      end
   end

   assign rd_valid = rd_valid_r;
   assign rd_pc    = rd_valid_r ? mem_pc_r[head_r]    : {PC_W{1'b0}};
   assign rd_class = rd_valid_r ? mem_class_r[head_r] : 5'd0;
   assign rd_wd    = rd_valid_r ? mem_wd_r[head_r]    : {DATA_W{1'b0}};
   assign count    = count_r;
   assign full     = full_r;
   assign drop_cnt = drop_r;
   assign cnt_out  = cnt_out_r;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed bench for instr_trace_buffer: fill/drain in both modes, concurrent push/pop,
// freeze/clear, class counters and asynchronous reset.
module tb_instr_trace_buffer;

   logic        clk, rst, ret_valid, mode, freeze, clear, rd_ready;
   logic [31:0] ret_pc, ret_instr, ret_wd, rd_pc, rd_wd;
   logic        rd_valid, full;
   logic [4:0]  rd_class, cnt_sel;
   logic [4:0]  count;
   logic [15:0] drop_cnt, cnt_out;
   int          compared = 0;
   int          failed   = 0;

   localparam logic [31:0] ADD_I = 32'h0109_5020;
   localparam logic [31:0] LW_I  = 32'h8D09_0004;

   instr_trace_buffer #(.DEPTH(16), .PC_W(32), .DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_pc(ret_pc),
      .ret_instr(ret_instr), .ret_wd(ret_wd), .mode(mode), .freeze(freeze),
      .clear(clear), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc),
      .rd_class(rd_class), .rd_wd(rd_wd), .count(count), .full(full),
      .drop_cnt(drop_cnt), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] wd);
      ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_wd = wd;
      step();
      ret_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b0; ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_wd = '0;
      mode = 1'b0; freeze = 1'b0; clear = 1'b0; rd_ready = 1'b0; cnt_sel = 5'd0;
      step(); step();
      check("reset_rd_valid", rd_valid, 1'b0);
      check("reset_count", count, 5'd0);
      check("reset_full", full, 1'b0);
      check("reset_drop", drop_cnt, 16'd0);
      check("reset_cnt_out", cnt_out, 16'd0);
      check("reset_rd_pc", rd_pc, 32'd0);
      rst = 1'b1;
      step();

      // Three retires: add, lw, nop
      retire(32'h00, ADD_I, 32'hAAAA_0001);
      check("first_push_visible", rd_valid, 1'b1);
      retire(32'h04, LW_I, 32'hBBBB_0002);
      retire(32'h08, 32'h0, 32'hCCCC_0003);
      check("three_count", count, 5'd3);
      cnt_sel = 5'd12;
      step();
      check("cnt_lw", cnt_out, 16'd1);
      cnt_sel = 5'd0;
      step();
      check("cnt_nop", cnt_out, 16'd1);
      cnt_sel = 5'd20;
      step();
      check("cnt_sel_out_of_range", cnt_out, 16'd0);
      check("head_wd", rd_wd, 32'hAAAA_0001);
      rd_ready = 1'b1;
      check("class0", rd_class, 5'd1);
      step();
      check("class1", rd_class, 5'd12);
      check("pc1", rd_pc, 32'h04);
      step();
      check("class2", rd_class, 5'd0);
      step();
      rd_ready = 1'b0;
      check("drained_valid", rd_valid, 1'b0);
      check("drained_pc_zero", rd_pc, 32'd0);
      pulse_clear();

      // Mode 0: 20 retires, 4 dropped
      mode = 1'b0;
      for (int i = 0; i < 20; i++) retire(32'(4 * i), ADD_I, 32'(i));
      check("m0_full", full, 1'b1);
      check("m0_count", count, 5'd16);
      check("m0_drop", drop_cnt, 16'd4);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("m0_drain_%0d", i), rd_pc, 64'(4 * i));
         step();
      end
      rd_ready = 1'b0;
      check("m0_empty_count", count, 5'd0);
      check("m0_empty_valid", rd_valid, 1'b0);
      pulse_clear();

      // Mode 1: 20 retires, 4 oldest overwritten
      mode = 1'b1;
      for (int i = 0; i < 20; i++) retire(32'(4 * i), ADD_I, 32'(i));
      check("m1_count", count, 5'd16);
      check("m1_drop", drop_cnt, 16'd4);
      rd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("m1_drain_%0d", i), rd_pc, 64'(32'h10 + 4 * i));
         step();
      end
      rd_ready = 1'b0;
      check("m1_empty_count", count, 5'd0);
      check("m1_empty_valid", rd_valid, 1'b0);
      pulse_clear();

      // Mode 0 full with simultaneous push and pop for 5 cycles
      mode = 1'b0;
      for (int i = 0; i < 16; i++) retire(32'(4 * i), ADD_I, 32'(i));
      for (int k = 0; k < 5; k++) begin
         ret_valid = 1'b1; ret_pc = 32'(32'h100 + 4 * k); ret_instr = LW_I; rd_ready = 1'b1;
         check($sformatf("pp_pop_%0d", k), rd_pc, 64'(4 * k));
         step();
         check($sformatf("pp_count_%0d", k), count, 5'd16);
      end
      ret_valid = 1'b0;
      check("pp_drop", drop_cnt, 16'd0);
      check("pp_full", full, 1'b1);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("pp_drain_%0d", i), rd_pc,
               (i < 11) ? 64'(32'h14 + 4 * i) : 64'(32'h100 + 4 * (i - 11)));
         step();
      end
      rd_ready = 1'b0;
      check("pp_empty", rd_valid, 1'b0);
      pulse_clear();

      // Freeze blocks pushes and counting; clear zeroes everything
      retire(32'h200, ADD_I, 32'h1);
      retire(32'h204, ADD_I, 32'h2);
      freeze = 1'b1;
      for (int i = 0; i < 4; i++) retire(32'(32'h300 + 4 * i), ADD_I, 32'h9);
      check("frz_count", count, 5'd2);
      cnt_sel = 5'd1;
      step();
      check("frz_cnt_add", cnt_out, 16'd2);
      freeze = 1'b0;
      mode = 1'b0;
      for (int i = 0; i < 14; i++) retire(32'(32'h400 + 4 * i), ADD_I, 32'h0);
      retire(32'h500, ADD_I, 32'h0);
      check("pre_clear_drop", drop_cnt, 16'd1);
      pulse_clear();
      check("clr_count", count, 5'd0);
      check("clr_drop", drop_cnt, 16'd0);
      check("clr_valid", rd_valid, 1'b0);
      for (int s = 0; s < 17; s++) begin
         cnt_sel = 5'(s);
         step();
         check($sformatf("clr_cnt_%0d", s), cnt_out, 16'd0);
      end

      // Asynchronous reset mid-cycle with 7 entries held
      for (int i = 0; i < 7; i++) retire(32'(4 * i), ADD_I, 32'(i));
      check("ar_count_before", count, 5'd7);
      #3;
      rst = 1'b0;
      #1;
      check("ar_valid", rd_valid, 1'b0);
      check("ar_count", count, 5'd0);
      step();
      rst = 1'b1;
      step();
      check("ar_still_empty", rd_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
